vga_timing_gen: RTL and testbench

//  Raster timing source producing the pixel coordinates x/y that every sprite/logo display unit consumes.

---
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 117 +++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel divider, x/y counters, registered hsync/vsync/video_on and frame_start.
// Build option: define VGA_SYNC_DELAY_EN to delay hsync/vsync/video_on by one pixel period.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       p_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  // Decode bounds are 11 bits wide so a full 1024-count raster cannot overflow them
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FP + V_SYNC);
  // {video_on, vsync, hsync} while idle
  localparam logic [2:0]  SYNC_IDLE = 3'b011;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end
  if (CLK_DIV < 2) begin : g_div_check
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [9:0]       x_reg, x_next, y_reg, y_next;
  logic             p_tick_reg, frame_start_reg;
  logic [2:0]       sync_reg, sync_next;
  logic             pix_end;
  logic [10:0]      x_ext, y_ext;

  always_comb begin
    pix_end      = (div_cnt_reg == DIV_LAST);
    div_cnt_next = pix_end ? '0 : div_cnt_reg + DIV_W'(1);
    x_next       = x_reg;
    y_next       = y_reg;
    if (pix_end) begin
      if (x_reg == H_LAST) begin
        x_next = '0;
        y_next = (y_reg == V_LAST) ? '0 : y_reg + 10'd1;
      end else begin
        x_next = x_reg + 10'd1;
      end
    end
    // Decode from the next-state counters so sync edges land on the same clk as x/y
    x_ext        = {1'b0, x_next};
    y_ext        = {1'b0, y_next};
    sync_next[0] = !((x_ext >= HS_START) && (x_ext < HS_END));
    sync_next[1] = !((y_ext >= VS_START) && (y_ext < VS_END));
    sync_next[2] = (x_ext < H_VIS) && (y_ext < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg     <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      p_tick_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
      sync_reg        <= SYNC_IDLE;
    end else begin
      div_cnt_reg     <= div_cnt_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      p_tick_reg      <= (div_cnt_next == DIV_LAST);
      frame_start_reg <= pix_end && (x_reg == H_LAST) && (y_reg == V_LAST);
      sync_reg        <= sync_next;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // CLK_DIV-deep shift line: one pixel period of lag to match the registered rgb stage
  genvar gi;
  for (gi = 0; gi < CLK_DIV; gi++) begin : g_dly
    logic [2:0] stage_reg;
    logic [2:0] stage_in;
    if (gi == 0) begin : g_first
      assign stage_in = sync_reg;
    end else begin : g_rest
      assign stage_in = g_dly[gi-1].stage_reg;
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        stage_reg <= SYNC_IDLE;
      end else begin
        stage_reg <= stage_in;
      end
    end
  end
  assign hsync    = g_dly[CLK_DIV-1].stage_reg[0];
  assign vsync    = g_dly[CLK_DIV-1].stage_reg[1];
  assign video_on = g_dly[CLK_DIV-1].stage_reg[2];
`else
  assign hsync    = sync_reg[0];
  assign vsync    = sync_reg[1];
  assign video_on = sync_reg[2];
`endif

  assign x           = x_reg;
  assign y           = y_reg;
  assign p_tick      = p_tick_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-reset bench for vga_timing_gen on a reduced raster; expected outputs are
// computed arithmetically from the number of clks elapsed since the last reset edge.
module tb_vga_timing_gen;

  localparam int CLK_DIV   = 2;
  localparam int H_DISPLAY = 16;
  localparam int H_FP      = 4;
  localparam int H_SYNC    = 6;
  localparam int H_BP      = 4;
  localparam int V_DISPLAY = 12;
  localparam int V_FP      = 2;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 3;
  localparam int H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CLKS = CLK_DIV * H_TOTAL * V_TOTAL;
`ifdef VGA_SYNC_DELAY_EN
  localparam int SYNC_LAG = CLK_DIV;
`else
  localparam int SYNC_LAG = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x, y;
  logic       video_on, hsync, vsync, p_tick, frame_start;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  logic checking = 1'b0;
  logic first_run = 1'b1;
  int vo_clks = 0, hs_low_clks = 0, vs_low_clks = 0, fs_pulses = 0;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_DISPLAY(H_DISPLAY), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISPLAY(V_DISPLAY), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
    .hsync(hsync), .vsync(vsync), .p_tick(p_tick), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // n: clks since the most recent edge that sampled reset high
  always @(posedge clk) n <= reset ? 0 : n + 1;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s n=%0d got=%0d expected=%0d", tag, n, got, exp);
    end
  endtask

  // {video_on, vsync, hsync} for the raster position reached m clks after reset
  function automatic logic [2:0] sync_at(input int m);
    int p, px, py;
    if (m <= 0) return 3'b011;
    p  = m / CLK_DIV;
    px = p % H_TOTAL;
    py = (p / H_TOTAL) % V_TOTAL;
    return {(px < H_DISPLAY) && (py < V_DISPLAY),
            !((py >= V_DISPLAY + V_FP) && (py < V_DISPLAY + V_FP + V_SYNC)),
            !((px >= H_DISPLAY + H_FP) && (px < H_DISPLAY + H_FP + H_SYNC))};
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      int p;
      logic [2:0] s;
      p = n / CLK_DIV;
      s = sync_at(n - SYNC_LAG);
      check("x", int'(x), p % H_TOTAL);
      check("y", int'(y), (p / H_TOTAL) % V_TOTAL);
      check("p_tick", int'(p_tick), int'(n % CLK_DIV == CLK_DIV - 1));
      check("frame_start", int'(frame_start), int'(n > 0 && n % FRAME_CLKS == 0));
      check("hsync", int'(hsync), int'(s[0]));
      check("vsync", int'(vsync), int'(s[1]));
      check("video_on", int'(video_on), int'(s[2]));
      if (first_run && n >= FRAME_CLKS && n < 2 * FRAME_CLKS) begin
        vo_clks     += int'(video_on);
        hs_low_clks += int'(!hsync);
        vs_low_clks += int'(!vsync);
        fs_pulses   += int'(frame_start);
      end
    end
  end

  initial begin
    int run_len;
    reset = 1'b1;
    @(negedge clk);
    checking = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (3 * FRAME_CLKS + 10) @(negedge clk);
    first_run = 1'b0;
    checking = 1'b0;
    check("frame_video_clks", vo_clks, H_DISPLAY * V_DISPLAY * CLK_DIV);
    check("frame_hsync_low_clks", hs_low_clks, H_SYNC * V_TOTAL * CLK_DIV);
    check("frame_vsync_low_clks", vs_low_clks, V_SYNC * H_TOTAL * CLK_DIV);
    check("frame_start_pulses", fs_pulses, 1);
    checking = 1'b1;
    for (int s = 0; s < 12; s++) begin
      reset = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      reset = 1'b0;
      run_len = $urandom_range(50, 2 * FRAME_CLKS);
      repeat (run_len) @(negedge clk);
    end
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
